program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream boot loader sitting directly upstream of the cpu core's program memory write port, which the core currently ties off.
- Receives a framed program image over an 8-bit valid/ready stream (UART RX or bench driver).
- Assembles little-endian 32-bit words and writes them into program memory.
- Holds the cpu in reset until the image is complete, then releases it.

Parameters:
- MEM_WORDS, 1024, program memory depth in 32-bit words; upper bound on accepted image length
- BASE_ADDR, 32'h0000_0000, byte address of first written word; must be 4-byte aligned

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  input byte valid
- rx_data  in  8  input byte
- rx_ready  out  1  loader can accept a byte
- start  in  1  single-cycle pulse; re-arms loader from DONE/ERROR
- mem_write_enable  out  1  program memory write strobe
- mem_byte_address  out  32  program memory byte address
- mem_write_data  out  32  program memory write word
- cpu_reset_n  out  1  active-low reset to cpu core; 1 only in DONE
- load_done  out  1  image loaded successfully
- load_error  out  1  image rejected
- words_loaded  out  $clog2(MEM_WORDS)+1  words written so far

Behaviour:
- Clock domain: single clock. Reset is asynchronous, active-high.
- Reset state: every output 0, including cpu_reset_n (cpu held in reset). FSM enters HDR; byte counter, word counter and assembly register are cleared.
- Byte acceptance: a byte is accepted on a cycle with rx_valid & rx_ready. rx_ready is 1 in HDR, LOAD and CSUM; 0 in WRITE, DONE and ERROR.
- Frame format:
  - 4-byte little-endian word count N.
  - Then N words, 4 bytes each, little-endian (first byte lands in [7:0]).
- Byte counter: 2 bits, wraps 3->0 on each accepted 4th byte.
- HDR:
  - On the 4th byte, latch N.
  - N==0: go to DONE.
  - N>MEM_WORDS: go to ERROR.
  - Otherwise: go to LOAD.
- LOAD: on the 4th byte of a word, go to WRITE.
- WRITE (exactly one cycle, registered outputs):
  - mem_write_enable=1, mem_byte_address=BASE_ADDR+4*words_loaded, mem_write_data=assembled word.
  - words_loaded increments at the end of the cycle.
  - Next state: LOAD if words_loaded+1<N; otherwise CSUM if feature enabled, else DONE.
  - Write latency is 1 cycle after the 4th byte is accepted. Throughput is at most one word per 5 cycles.
- mem_write_enable is 0 in all other states. Address and data outputs hold their last values.
- DONE: cpu_reset_n=1 and load_done=1 (registered, so the cpu is released one cycle after entering DONE).
- ERROR: load_error=1 and cpu_reset_n=0.
- start:
  - Ignored in HDR/LOAD/WRITE/CSUM.
  - In DONE/ERROR: go to HDR next cycle, clear counters and flags, cpu_reset_n=0.
- Reset mid-load: return to HDR immediately. Partial memory contents are not cleared.
- rx_valid with rx_ready=0: the byte is not consumed. The upstream block holds it (standard valid/ready).

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN
- Enabled:
  - A 32-bit running sum (mod 2^32) is kept over all written words; the header is not included.
  - After the last word, CSUM state receives 4 bytes, little-endian.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
  - N==0 still requires CSUM, with expected value 0.
- Disabled: no CSUM state and no sum register. The frame ends after the last data word.

Decomposition:
- common package:
  - loader_state_e enum (HDR, LOAD, WRITE, CSUM, DONE, ERROR).
  - LOADER_BYTES_PER_WORD=4 constant.
- One sub-module, byte_to_word_packer:
  - Holds the 2-bit byte counter and 32-bit shift register.
  - Emits word_valid on the 4th byte.
  - Reused by HDR, LOAD and CSUM.

Test Plan:
- Load 3 words:
  - Stimulus: bytes 03 00 00 00, EF BE AD DE, 01 00 00 00, 78 56 34 12.
  - Response: writes 0xDEADBEEF@0x0, 0x00000001@0x4, 0x12345678@0x8; words_loaded=3; load_done=1; cpu_reset_n rises one cycle after DONE.
- Oversize header, N=1025 (01 04 00 00) with MEM_WORDS=1024: load_error=1, rx_ready=0, no write strobes, cpu_reset_n stays 0.
- Zero length, header 00 00 00 00 (checksum disabled): DONE immediately, no writes.
- Backpressure/gaps: random rx_valid gaps within a word; writes are identical to the gap-free case. Bytes offered during WRITE are not consumed.
- Reset after 6 bytes, then a full 1-word image AA BB CC DD: single write 0xDDCCBBAA@BASE_ADDR; words_loaded=1.
- Checksum enabled, words 1 and 2:
  - Trailer 03 00 00 00: DONE.
  - Trailer 04 00 00 00: ERROR.
  - start pulse after ERROR: returns to HDR with counters 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
//   loader_state_e        : loader FSM states
//   LOADER_BYTES_PER_WORD : bytes assembled into one program word
package program_loader_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_e;

  localparam int LOADER_BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_to_word_packer.sv
// Assembles accepted bytes into little-endian 32-bit words.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear of byte counter and assembly register
//   byte_valid  : a byte is being accepted this cycle
//   byte_data   : the byte being accepted
//   word_valid  : this cycle's byte completes a word
//   word        : completed word (valid with word_valid); first byte in [7:0]
module program_loader_byte_to_word_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_count;
  // Holds the three earlier bytes of the word; the fourth byte is taken
  // straight from byte_data so the word is available in the same cycle.
  logic [23:0] shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= 2'd0;
      shift_q    <= 24'd0;
    end else if (clear) begin
      byte_count <= 2'd0;
      shift_q    <= 24'd0;
    end else if (byte_valid) begin
      byte_count <= byte_count + 2'd1;
      shift_q    <= {byte_data, shift_q[23:8]};
    end
  end

  assign word_valid = byte_valid && (byte_count == 2'(LOADER_BYTES_PER_WORD - 1));
  assign word       = {byte_data, shift_q};

endmodule

// File: rtl/program_loader.sv
// Byte-stream boot loader feeding the cpu program memory write port.
// Frame: 4-byte LE word count N, then N LE words (then a 4-byte LE sum of
// the words when PROG_LOADER_CHECKSUM_EN is defined). The cpu is held in
// reset until the image is complete.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   rx_valid/rx_data   : input byte stream
//   rx_ready           : byte accepted on rx_valid & rx_ready
//   start              : re-arms the loader from DONE/ERROR
//   mem_write_enable   : one-cycle write strobe (WRITE state)
//   mem_byte_address   : BASE_ADDR + 4*words_loaded, held between writes
//   mem_write_data     : assembled word, held between writes
//   cpu_reset_n        : 1 only while DONE (one cycle after entry)
//   load_done/error    : image accepted / rejected
//   words_loaded       : words written so far
//   fsm_state          : current FSM state (debug)
// Handshake: a byte transfers on any rising edge where rx_valid and
// rx_ready are both 1; when rx_ready is 0 the sender holds the byte.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  input  logic                       start,
  output logic                       mem_write_enable,
  output logic [31:0]                mem_byte_address,
  output logic [31:0]                mem_write_data,
  output logic                       cpu_reset_n,
  output logic                       load_done,
  output logic                       load_error,
  output logic [$clog2(MEM_WORDS):0] words_loaded,
  output loader_state_e              fsm_state
);

  localparam int CW = $clog2(MEM_WORDS) + 1;

  loader_state_e state, state_next;
  logic          accept;
  logic          rearm;
  logic          word_valid;
  logic [31:0]   word;
  logic [31:0]   word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]   sum;
`endif

  assign fsm_state = state;
  assign rx_ready  = (state == HDR) || (state == LOAD) || (state == CSUM);
  assign accept    = rx_valid && rx_ready;
  assign rearm     = start && ((state == DONE) || (state == ERROR));

  program_loader_byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (reset),
    .clear      (rearm),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HDR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (word_valid) begin
          if (word == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else if (word > 32'(MEM_WORDS)) begin
            state_next = ERROR;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_valid) state_next = WRITE;
      end
      WRITE: begin
        // words_loaded still holds the pre-increment count in this cycle.
        if ((32'(words_loaded) + 32'd1) < word_count) begin
          state_next = LOAD;
        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
      CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (word_valid) state_next = (word == sum) ? DONE : ERROR;
`else
        state_next = ERROR;
`endif
      end
      DONE, ERROR: begin
        if (start) state_next = HDR;
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count       <= 32'd0;
      words_loaded     <= '0;
      mem_write_enable <= 1'b0;
      mem_byte_address <= 32'd0;
      mem_write_data   <= 32'd0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
      cpu_reset_n      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum              <= 32'd0;
`endif
    end else begin
      // Status flags follow the state one cycle late; a start pulse drops
      // them on the same edge that leaves DONE/ERROR.
      load_done        <= (state == DONE) && !start;
      load_error       <= (state == ERROR) && !start;
      cpu_reset_n      <= (state == DONE) && !start;
      mem_write_enable <= (state_next == WRITE);

      if (state == HDR && word_valid) word_count <= word;

      if (state == LOAD && word_valid) begin
        mem_write_data   <= word;
        mem_byte_address <= BASE_ADDR + (32'(words_loaded) << 2);
`ifdef PROG_LOADER_CHECKSUM_EN
        sum              <= sum + word;
`endif
      end

      if (state == WRITE) words_loaded <= words_loaded + CW'(1);

      if (rearm) begin
        words_loaded <= '0;
        word_count   <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum          <= 32'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (default MEM_WORDS/BASE_ADDR).
// Honours PROG_LOADER_CHECKSUM_EN by appending checksum trailers.
module tb_program_loader;
  import program_loader_pkg::*;

  logic          clk;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          start;
  logic          mem_write_enable;
  logic [31:0]   mem_byte_address;
  logic [31:0]   mem_write_data;
  logic          cpu_reset_n;
  logic          load_done;
  logic          load_error;
  logic [10:0]   words_loaded;
  loader_state_e fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int write_cnt = 0;
  logic [63:0] exp_q[$];

  program_loader #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (rst),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_ready         (rx_ready),
    .start            (start),
    .mem_write_enable (mem_write_enable),
    .mem_byte_address (mem_byte_address),
    .mem_write_data   (mem_write_data),
    .cpu_reset_n      (cpu_reset_n),
    .load_done        (load_done),
    .load_error       (load_error),
    .words_loaded     (words_loaded),
    .fsm_state        (fsm_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(posedge clk) begin
    #1;
    if (!rst && mem_write_enable) begin
      write_cnt++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed %0h@%0h expected no write",
               mem_write_data, mem_byte_address);
      end
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {mem_byte_address, mem_write_data}, e);
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, gap_max));
  endtask

  task automatic wait_state(input loader_state_e target, input string tag);
    int n;
    n = 0;
    while (fsm_state != target && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(fsm_state), 64'(target));
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_state"}, 64'(fsm_state), 64'(HDR));
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_flags"}, {61'd0, load_done, load_error, cpu_reset_n}, 64'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_we", 64'(mem_write_enable), 64'd0);
    check("rst_addr_data", {mem_byte_address, mem_write_data}, 64'd0);
    check("rst_flags", {61'd0, load_done, load_error, cpu_reset_n}, 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(HDR));
    rst = 1'b0;
    @(negedge clk);

    // three-word image, gaps within words, bytes offered during WRITE
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    exp_q.push_back({32'h0000_0004, 32'h0000_0001});
    exp_q.push_back({32'h0000_0008, 32'h1234_5678});
    send_word(32'd3, 0);
    check("t1_hdr_to_load", 64'(fsm_state), 64'(LOAD));
    send_word(32'hDEAD_BEEF, 0);
    check("t1_write_state", 64'(fsm_state), 64'(WRITE));
    check("t1_we_latency", 64'(mem_write_enable), 64'd1);
    check("t1_ready_in_write", 64'(rx_ready), 64'd0);
    check("t1_cpu_held", 64'(cpu_reset_n), 64'd0);
    send_word(32'h0000_0001, 3);
    send_word(32'h1234_5678, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hF0E2_1568, 1);
`endif
    wait_state(DONE, "t1_done");
    check("t1_cpu_not_yet", 64'(cpu_reset_n), 64'd0);
    @(negedge clk);
    check("t1_cpu_released", 64'(cpu_reset_n), 64'd1);
    check("t1_load_done", 64'(load_done), 64'd1);
    check("t1_no_error", 64'(load_error), 64'd0);
    check("t1_words", 64'(words_loaded), 64'd3);
    check("t1_write_cnt", 64'(write_cnt), 64'd3);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_start("t1_rearm");

    // oversize header N=1025
    w0 = write_cnt;
    send_word(32'd1025, 0);
    check("t2_error_state", 64'(fsm_state), 64'(ERROR));
    check("t2_ready_low", 64'(rx_ready), 64'd0);
    @(negedge clk);
    check("t2_load_error", 64'(load_error), 64'd1);
    check("t2_cpu_held", 64'(cpu_reset_n), 64'd0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    check("t2_stays_error", 64'(fsm_state), 64'(ERROR));
    check("t2_no_writes", 64'(write_cnt), 64'(w0));
    pulse_start("t2_rearm");

    // zero-length image
    w0 = write_cnt;
    send_word(32'd0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("t3_csum_state", 64'(fsm_state), 64'(CSUM));
    send_word(32'd0, 0);
`endif
    check("t3_done_state", 64'(fsm_state), 64'(DONE));
    @(negedge clk);
    check("t3_load_done", 64'(load_done), 64'd1);
    check("t3_cpu_released", 64'(cpu_reset_n), 64'd1);
    check("t3_no_writes", 64'(write_cnt), 64'(w0));
    pulse_start("t3_rearm");

    // reset after 6 bytes, then a one-word image
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_state", 64'(fsm_state), 64'(HDR));
    check("t4_rst_words", 64'(words_loaded), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    w0 = write_cnt;
    exp_q.push_back({32'h0000_0000, 32'hDDCC_BBAA});
    send_word(32'd1, 0);
    send_word(32'hDDCC_BBAA, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hDDCC_BBAA, 0);
`endif
    wait_state(DONE, "t4_done");
    @(negedge clk);
    check("t4_words", 64'(words_loaded), 64'd1);
    check("t4_load_done", 64'(load_done), 64'd1);
    check("t4_one_write", 64'(write_cnt - w0), 64'd1);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_start("t4_rearm");

`ifdef PROG_LOADER_CHECKSUM_EN
    // checksum match and mismatch
    exp_q.push_back({32'h0000_0000, 32'h0000_0001});
    exp_q.push_back({32'h0000_0004, 32'h0000_0002});
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'd3, 0);
    check("t5_match_done", 64'(fsm_state), 64'(DONE));
    @(negedge clk);
    check("t5_match_flag", 64'(load_done), 64'd1);
    pulse_start("t5_rearm");
    exp_q.push_back({32'h0000_0000, 32'h0000_0001});
    exp_q.push_back({32'h0000_0004, 32'h0000_0002});
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'd4, 0);
    check("t5_mismatch_error", 64'(fsm_state), 64'(ERROR));
    @(negedge clk);
    check("t5_mismatch_flag", 64'(load_error), 64'd1);
    check("t5_cpu_held", 64'(cpu_reset_n), 64'd0);
    pulse_start("t5_rearm_err");
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
